s2p_lanes: RTL and testbench

Parametrised multi-lane serial-to-parallel converter, the successor to the single-lane 4-bit s2p. It deserialises LANES serial inputs in lock-step into WIDTH-bit words, with selectable bit order. Completed words are presented through a one-entry valid/ready output register, so the block can feed back-pressured downstream logic such as FIFOs or bus masters. It sits between pin-level serial receivers and word-oriented datapath logic.

---
 rtl/s2p_pkg.sv | 19 +
 rtl/s2p_lane.sv | 42 ++++
 rtl/s2p_lanes.sv | 83 ++++++++
 tb/tb_s2p_lanes.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the s2p family of serial-to-parallel blocks.
//   calc_cnt_w(width) : bit counter width, clog2(width) with a floor of 1
//   CNT_W             : counter width for the default 8-bit word
//   lane_lo(k, width) : low bit index of lane k in a packed multi-lane word
package s2p_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned calc_cnt_w(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int unsigned CNT_W = calc_cnt_w(DEFAULT_WIDTH);

    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/s2p_lane.sv
// s2p_lane: one lane's WIDTH-bit deserialising shift register.
//   clk, rst  : clock, asynchronous active-high reset
//   shift     : shift si into the register this cycle
//   clr       : synchronous clear, wins over shift
//   si        : serial input bit
//   word_next : register contents including this cycle's bit (pre-edge view),
//               used by the top to capture a word on its completing edge
module s2p_lane #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clr,
    input  logic             si,
    output logic [WIDTH-1:0] word_next
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = sr;
        if (MSB_FIRST)
            shifted = {sr[WIDTH-2:0], si};
        else
            shifted = {si, sr[WIDTH-1:1]};
    end

    assign word_next = shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= '0;
        else if (clr)
            sr <= '0;
        else if (shift)
            sr <= shifted;
    end

endmodule

// File: rtl/s2p_lanes.sv
// s2p_lanes: LANES lock-stepped serial lanes deserialised into WIDTH-bit words,
// presented through a one-entry valid/ready output register.
//   clk, rst   : clock, asynchronous active-high reset
//   si         : one serial bit per lane, sampled when dat_en=1
//   dat_en     : bit strobe
//   clr        : synchronous realign, discards the partial word (beats dat_en)
//   po         : output word, lane k at po[k*WIDTH +: WIDTH]
//   dat_valid  : po holds an unconsumed word
//   dat_ready  : downstream accepts po when dat_valid & dat_ready
//   overflow   : one-cycle pulse per completed word dropped under back-pressure
module s2p_lanes
    import s2p_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       si,
    input  logic                   dat_en,
    input  logic                   clr,
    output logic [LANES*WIDTH-1:0] po,
    output logic                   dat_valid,
    input  logic                   dat_ready,
    output logic                   overflow
);

    localparam int unsigned LCNT_W = calc_cnt_w(WIDTH);
    localparam logic [LCNT_W-1:0] CNT_MAX = LCNT_W'(WIDTH - 1);

    logic [LCNT_W-1:0]      cnt;
    logic [LANES*WIDTH-1:0] cand;
    logic                   complete;
    logic                   free;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned LO = lane_lo(k, WIDTH);
        s2p_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .shift     (dat_en),
            .clr       (clr),
            .si        (si[k]),
            .word_next (cand[LO +: WIDTH])
        );
    end

    // A clr in the completing cycle suppresses the word.
    assign complete = dat_en && !clr && (cnt == CNT_MAX);
    assign free     = !dat_valid || dat_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (dat_en)
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + LCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po        <= '0;
            dat_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (complete && free) begin
                po        <= cand;
                dat_valid <= 1'b1;
            end else if (complete) begin
                overflow <= 1'b1;
            end else if (dat_ready) begin
                dat_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_lanes.sv
// tb_s2p_lanes: directed self-checking bench for s2p_lanes (WIDTH=4, LANES=2),
// with an MSB-first and an LSB-first instance driven by the same stimulus.
module tb_s2p_lanes;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] si;
    logic       dat_en;
    logic       clr;
    logic       dat_ready;

    logic [7:0] po_a, po_b;
    logic       valid_a, valid_b;
    logic       ov_a, ov_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    s2p_lanes #(.WIDTH(4), .LANES(2), .MSB_FIRST(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .si        (si),
        .dat_en    (dat_en),
        .clr       (clr),
        .po        (po_a),
        .dat_valid (valid_a),
        .dat_ready (dat_ready),
        .overflow  (ov_a)
    );

    s2p_lanes #(.WIDTH(4), .LANES(2), .MSB_FIRST(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .si        (si),
        .dat_en    (dat_en),
        .clr       (clr),
        .po        (po_b),
        .dat_valid (valid_b),
        .dat_ready (dat_ready),
        .overflow  (ov_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic en, input logic [1:0] s, input logic c, input logic r);
        dat_en    = en;
        si        = s;
        clr       = c;
        dat_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; si = '0; dat_en = 1'b0; clr = 1'b0; dat_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset_po", po_a, 8'h00);
        chk("reset_valid", {7'b0, valid_a}, 8'h00);
        chk("reset_ov", {7'b0, ov_a}, 8'h00);
        rst = 1'b0;

        // Basic: lane0 1,0,1,0 / lane1 0,1,0,1 (si = {lane1, lane0})
        cyc(1, 2'b01, 0, 1);
        cyc(1, 2'b10, 0, 1);
        cyc(1, 2'b01, 0, 1);
        chk("basic_not_yet", {7'b0, valid_a}, 8'h00);
        cyc(1, 2'b10, 0, 1);
        chk("basic_po", po_a, 8'h5A);
        chk("basic_valid", {7'b0, valid_a}, 8'h01);
        chk("order_po", po_b, 8'hA5);
        chk("order_valid", {7'b0, valid_b}, 8'h01);
        cyc(0, 2'b00, 0, 1);
        chk("basic_valid_drop", {7'b0, valid_a}, 8'h00);
        chk("basic_po_hold", po_a, 8'h5A);

        // Pause: 3 idle cycles after the second bit
        cyc(1, 2'b01, 0, 1);
        cyc(1, 2'b10, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 2'b11, 0, 1);
            chk("pause_valid", {7'b0, valid_a}, 8'h00);
        end
        cyc(1, 2'b01, 0, 1);
        cyc(1, 2'b10, 0, 1);
        chk("pause_po", po_a, 8'h5A);
        chk("pause_valid_done", {7'b0, valid_a}, 8'h01);
        cyc(0, 2'b00, 0, 1);

        // Back-pressure: two words, no ready. Word 2 is lane0 1100, lane1 0011.
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        chk("bp_first_po", po_a, 8'h5A);
        chk("bp_first_ov", {7'b0, ov_a}, 8'h00);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        chk("bp_no_early_ov", {7'b0, ov_a}, 8'h00);
        cyc(1, 2'b10, 0, 0);
        chk("bp_ov_pulse", {7'b0, ov_a}, 8'h01);
        chk("bp_po_kept", po_a, 8'h5A);
        chk("bp_valid", {7'b0, valid_a}, 8'h01);
        chk("bp_ov_pulse_b", {7'b0, ov_b}, 8'h01);
        cyc(0, 2'b00, 0, 0);
        chk("bp_ov_one_cycle", {7'b0, ov_a}, 8'h00);
        chk("bp_valid_held", {7'b0, valid_a}, 8'h01);
        cyc(0, 2'b00, 0, 1);
        chk("bp_accept", {7'b0, valid_a}, 8'h00);
        chk("bp_po_after", po_a, 8'h5A);

        // Same-edge accept: 5A held, ready rises on the edge completing 3C
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        chk("same_first", po_a, 8'h5A);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        chk("same_valid_mid", {7'b0, valid_a}, 8'h01);
        cyc(1, 2'b10, 0, 1);
        chk("same_po", po_a, 8'h3C);
        chk("same_valid", {7'b0, valid_a}, 8'h01);
        chk("same_no_ov", {7'b0, ov_a}, 8'h00);
        cyc(0, 2'b00, 0, 1);
        chk("same_drain", {7'b0, valid_a}, 8'h00);

        // Realign: clr after 2 bits (with dat_en high), then 1111 on both lanes
        cyc(1, 2'b01, 0, 1);
        cyc(1, 2'b10, 0, 1);
        cyc(1, 2'b11, 1, 1);
        cyc(1, 2'b11, 0, 1);
        cyc(1, 2'b11, 0, 1);
        cyc(1, 2'b11, 0, 1);
        chk("clr_not_yet", {7'b0, valid_a}, 8'h00);
        cyc(1, 2'b11, 0, 1);
        chk("clr_po", po_a, 8'hFF);
        chk("clr_po_b", po_b, 8'hFF);
        chk("clr_valid", {7'b0, valid_a}, 8'h01);

        // clr on the would-be completing cycle suppresses the word
        cyc(1, 2'b00, 0, 1);
        cyc(1, 2'b00, 0, 1);
        cyc(1, 2'b00, 0, 1);
        cyc(1, 2'b00, 1, 1);
        chk("clr_suppress_valid", {7'b0, valid_a}, 8'h00);
        chk("clr_suppress_po", po_a, 8'hFF);

        // Reset mid-word with a pending word
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b11, 0, 0);
        chk("pre_rst_valid", {7'b0, valid_a}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("rst_po", po_a, 8'h00);
        chk("rst_valid", {7'b0, valid_a}, 8'h00);
        chk("rst_ov", {7'b0, ov_a}, 8'h00);
        rst = 1'b0;
        cyc(1, 2'b01, 0, 1);
        cyc(1, 2'b10, 0, 1);
        cyc(1, 2'b01, 0, 1);
        chk("rst_fresh_not_yet", {7'b0, valid_a}, 8'h00);
        cyc(1, 2'b10, 0, 1);
        chk("rst_fresh_po", po_a, 8'h5A);
        chk("rst_fresh_valid", {7'b0, valid_a}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
